// File: rtl/mips32_prog_loader.sv
// Byte-stream image loader for the MIPS32 unified memory: parses framed words,
// writes them through the shared write port and releases the CPU on a good checksum.
module mips32_prog_loader #(
    parameter int         ADDR_W = 10,
    parameter logic [7:0] MAGIC  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ADDR_H = 4'd1,
        S_ADDR_L = 4'd2,
        S_CNT_H  = 4'd3,
        S_CNT_L  = 4'd4,
        S_DATA   = 4'd5,
        S_CSUM   = 4'd6,
        S_DONE   = 4'd7,
        S_ERR    = 4'd8
    } state_t;

    state_t              state_r;
    logic [7:0]          addr_h_r;
    logic [7:0]          cnt_h_r;
    logic [7:0]          csum_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [15:0]         word_cnt_r;
    logic [1:0]          byte_cnt_r;
    logic [23:0]         asm_r;

    logic                accept_s;
    logic [15:0]         hdr_addr_s;
    logic [15:0]         hdr_cnt_s;
    logic [31:0]         word_s;

    // Byte handshake and the header/word values formed with the byte on the bus
    always_comb begin
        accept_s   = in_valid & in_ready;
        hdr_addr_s = {addr_h_r, in_data};
        hdr_cnt_s  = {cnt_h_r, in_data};
        word_s     = {asm_r, in_data};
    end

    // Frame parser FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            addr_h_r   <= 8'd0;
            cnt_h_r    <= 8'd0;
            csum_r     <= 8'd0;
            addr_r     <= '0;
            word_cnt_r <= 16'd0;
            byte_cnt_r <= 2'd0;
            asm_r      <= 24'd0;
        end else begin
            mem_we <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept_s && (in_data == MAGIC)) begin
                        state_r <= S_ADDR_H;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ADDR_H: begin
                    in_ready <= 1'b1;
                    if (accept_s) begin
                        addr_h_r <= in_data;
                        state_r  <= S_ADDR_L;
                    end else begin
                        state_r  <= S_ADDR_H;
                    end
                end
                S_ADDR_L: begin
                    in_ready <= 1'b1;
                    if (accept_s) begin
                        addr_r  <= hdr_addr_s[ADDR_W-1:0];
                        state_r <= S_CNT_H;
                    end else begin
                        state_r <= S_ADDR_L;
                    end
                end
                S_CNT_H: begin
                    in_ready <= 1'b1;
                    if (accept_s) begin
                        cnt_h_r <= in_data;
                        state_r <= S_CNT_L;
                    end else begin
                        state_r <= S_CNT_H;
                    end
                end
                S_CNT_L: begin
                    in_ready <= 1'b1;
                    if (accept_s) begin
                        word_cnt_r <= hdr_cnt_s;
                        byte_cnt_r <= 2'd0;
                        state_r    <= (hdr_cnt_s == 16'd0) ? S_CSUM : S_DATA;
                    end else begin
                        state_r    <= S_CNT_L;
                    end
                end
                S_DATA: begin
                    in_ready <= 1'b1;
                    if (accept_s) begin
                        csum_r     <= csum_r ^ in_data;
                        asm_r      <= word_s[23:0];
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            // Fire-and-forget write; the port never back-pressures
                            mem_we     <= 1'b1;
                            mem_addr   <= addr_r;
                            mem_wdata  <= word_s;
                            addr_r     <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                            word_cnt_r <= word_cnt_r - 16'd1;
                            state_r    <= (word_cnt_r == 16'd1) ? S_CSUM : S_DATA;
                        end else begin
                            state_r    <= S_DATA;
                        end
                    end else begin
                        state_r <= S_DATA;
                    end
                end
                S_CSUM: begin
                    if (accept_s) begin
                        in_ready <= 1'b0;
                        if (in_data == csum_r) begin
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                            state_r   <= S_DONE;
                        end else begin
                            load_err  <= 1'b1;
                            state_r   <= S_ERR;
                        end
                    end else begin
                        in_ready <= 1'b1;
                        state_r  <= S_CSUM;
                    end
                end
                S_DONE, S_ERR: begin
                    in_ready <= start;
                    if (start) begin
                        load_done  <= 1'b0;
                        load_err   <= 1'b0;
                        cpu_hold   <= 1'b1;
                        csum_r     <= 8'd0;
                        byte_cnt_r <= 2'd0;
                        state_r    <= S_IDLE;
                    end else begin
                        state_r    <= state_r;
                    end
                end
                default: begin
                    in_ready <= 1'b0;
                    state_r  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader: streams frames byte by byte and
// checks the memory write log, handshake and status flags.
module tb_mips32_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    mips32_prog_loader #(.ADDR_W(10), .MAGIC(8'hA5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Write log filled by the monitor; the main process only reads it
    int          wr_total = 0;
    logic [9:0]  wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_cyc  [64];

    logic [31:0] frame_words [16];

    always @(posedge clk) cyc <= cyc + 1;

    // mem_we lasts one full cycle, so each write is seen on exactly one falling edge
    always @(negedge clk) begin
        if (mem_we && (wr_total < 64)) begin
            wr_addr[wr_total] = mem_addr;
            wr_data[wr_total] = mem_wdata;
            wr_cyc[wr_total]  = cyc;
            wr_total          = wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the byte transfers
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int n;
        in_valid = 1'b0;
        if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] addr, input int n, input logic bad_csum, input int max_gap);
        logic [7:0] cs;
        logic [31:0] w;
        cs = 8'h00;
        send_byte(8'hA5, max_gap);
        send_byte(addr[15:8], max_gap);
        send_byte(addr[7:0], max_gap);
        send_byte(8'(n >> 8), max_gap);
        send_byte(8'(n), max_gap);
        for (int i = 0; i < n; i++) begin
            w = frame_words[i];
            for (int k = 3; k >= 0; k--) begin
                send_byte(w[k*8 +: 8], max_gap);
                cs = cs ^ w[k*8 +: 8];
            end
        end
        send_byte(bad_csum ? ~cs : cs, max_gap);
        @(negedge clk);
    endtask

    task automatic check_writes(input string tag, input int base, input int addr0, input int n);
        check({tag, "_count"}, 32'(wr_total - base), 32'(n));
        for (int i = 0; i < n && i < wr_total - base; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[base+i]), 32'((addr0 + i) % 1024));
            check($sformatf("%s_data%0d", tag, i), wr_data[base+i], frame_words[i]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_done_clr", 32'(load_done), 32'd0);
        check("start_err_clr", 32'(load_err), 32'd0);
        check("start_hold", 32'(cpu_hold), 32'd1);
        check("start_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic check_flags(input string tag, input logic done, input logic err, input logic hold, input logic rdy);
        check({tag, "_done"}, 32'(load_done), 32'(done));
        check({tag, "_err"}, 32'(load_err), 32'(err));
        check({tag, "_hold"}, 32'(cpu_hold), 32'(hold));
        check({tag, "_ready"}, 32'(in_ready), 32'(rdy));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(load_done), 32'd0);
        check({tag, "_err"}, 32'(load_err), 32'd0);
    endtask

    int base;
    logic [31:0] fact [11] = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000,
                               32'h0e94a000, 32'h14431000, 32'h2c630001, 32'h0e94a000,
                               32'h3460fffc, 32'h2542fffe, 32'hfc000000};

    initial begin
        rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        #1 check("ready_at_release", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("ready_after_release", 32'(in_ready), 32'd1);

        // One word, stream A5 00 00 00 01 28 0A 00 C8 EA
        base = wr_total;
        frame_words[0] = 32'h280a00c8;
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h28, 0);
        send_byte(8'h0A, 0); send_byte(8'h00, 0); send_byte(8'hC8, 0);
        send_byte(8'hEA, 0);
        check_writes("one", base, 0, 1);
        check_flags("one", 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_start();

        // Factorial image then a second frame at 200
        base = wr_total;
        for (int i = 0; i < 11; i++) frame_words[i] = fact[i];
        send_frame(16'h0000, 11, 1'b0, 0);
        check_writes("fact", base, 0, 11);
        check_flags("fact", 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_start();
        base = wr_total;
        frame_words[0] = 32'h00000007;
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'hC8, 0);
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h07, 0);
        send_byte(8'h07, 0);
        check_writes("f200", base, 200, 1);
        check_flags("f200", 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_start();

        // Bad checksum: word still written, error latched
        base = wr_total;
        frame_words[0] = 32'h280a00c8;
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h28, 0);
        send_byte(8'h0A, 0); send_byte(8'h00, 0); send_byte(8'hC8, 0);
        send_byte(8'h00, 0);
        check_writes("bad", base, 0, 1);
        check_flags("bad", 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("bad_err_held", 32'(load_err), 32'd1);
        // start together with a MAGIC byte: start wins, byte not taken
        in_data = 8'hA5; in_valid = 1'b1;
        pulse_start();
        in_valid = 1'b0;

        // Garbage bytes then a frame that wraps the address
        base = wr_total;
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        frame_words[0] = 32'hdeadbeef;
        frame_words[1] = 32'h01234567;
        send_frame(16'h03FF, 2, 1'b0, 0);
        check_writes("wrap", base, 1023, 2);
        check_flags("wrap", 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_start();

        // Count 0: A5 00 10 00 00 00
        base = wr_total;
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h10, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        @(negedge clk);
        check("cnt0_writes", 32'(wr_total - base), 32'd0);
        check_flags("cnt0", 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_start();

        // Four words with random valid gaps
        base = wr_total;
        frame_words[0] = 32'h11223344; frame_words[1] = 32'h55667788;
        frame_words[2] = 32'h99aabbcc; frame_words[3] = 32'hddeeff00;
        send_frame(16'h0040, 4, 1'b0, 3);
        check_writes("gap", base, 64, 4);
        check_flags("gap", 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_start();

        // Same four words at full rate: writes exactly 4 cycles apart
        base = wr_total;
        send_frame(16'h0080, 4, 1'b0, 0);
        check_writes("full", base, 128, 4);
        for (int i = 0; i < 3 && base + i + 1 < wr_total; i++)
            check($sformatf("full_space%0d", i), 32'(wr_cyc[base+i+1] - wr_cyc[base+i]), 32'd4);
        pulse_start();

        // Reset after two data bytes: no write, outputs back to reset values
        base = wr_total;
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h20, 0);
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        check("midrst_writes", 32'(wr_total - base), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        base = wr_total;
        frame_words[0] = 32'hcafef00d;
        send_frame(16'h0020, 1, 1'b0, 0);
        check_writes("after_rst", base, 32, 1);
        check_flags("after_rst", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
